// File: rtl/mux4_rr_arbiter.sv
// Purpose : round-robin owner arbiter for a 4:1 tristate bus mux, with a dead GAP cycle between owners.
// Latency : 1 cycle from the sampling edge to registered gnt/sel/bus_en.
// Backpressure: requesters hold req level until granted; an owner is preempted after HOLD_MAX cycles if others wait.
//
// Ports:
//   clk       - single clock, all state on rising edge
//   rst_n     - synchronous active-low reset
//   req[3:0]  - level requests, bit0=a .. bit3=d
//   gnt[3:0]  - registered one-hot grant, zero when no owner
//   sel[1:0]  - registered mux select, holds last owner outside GRANT
//   bus_en    - registered tristate enable, high only in GRANT
//   owner_cnt - consecutive grant count of the current owner
module mux4_rr_arbiter #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic [3:0] owner_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(HOLD_MAX - 1);

   state_t     state, state_nxt;
   logic [1:0] last_owner, last_owner_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] sel_nxt;
   logic       bus_en_nxt;
   logic [3:0] cnt_nxt;

   logic [1:0] win;
   logic       found;
   logic [1:0] idx;
   logic [3:0] others;

   // Round-robin pick: scan from last_owner+1, wrapping; first set request wins.
   always_comb begin
      win   = last_owner;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_owner + 2'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Requests from anyone other than the current owner.
   assign others = req & ~(4'b0001 << last_owner);

   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      gnt_nxt        = 4'b0000;
      sel_nxt        = sel;
      bus_en_nxt     = 1'b0;
      cnt_nxt        = 4'd0;
      case (state)
         IDLE, GAP: begin
            if (found) begin
               state_nxt      = GRANT;
               last_owner_nxt = win;
               gnt_nxt        = 4'b0001 << win;
               sel_nxt        = win;
               bus_en_nxt     = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         GRANT: begin
            // Owner released, or its hold budget is spent while someone else waits:
            // insert a dead cycle so two tristate drivers never overlap.
            if (!req[last_owner] || (owner_cnt == CNT_MAX && others != 4'b0000)) begin
               state_nxt = GAP;
            end else begin
               gnt_nxt    = gnt;
               bus_en_nxt = 1'b1;
               cnt_nxt    = (owner_cnt < CNT_MAX) ? owner_cnt + 4'd1 : owner_cnt;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 2'd3;
         gnt        <= 4'b0000;
         sel        <= 2'd0;
         bus_en     <= 1'b0;
         owner_cnt  <= 4'd0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         gnt        <= gnt_nxt;
         sel        <= sel_nxt;
         bus_en     <= bus_en_nxt;
         owner_cnt  <= cnt_nxt;
      end
   end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, SHALL set the maximum consecutive GRANT cycles an owner keeps the bus while another requester waits; legal range 1..15.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-004 Port req, input, 4, SHALL be per-requester bus requests (bit0=a, bit1=b, bit2=c, bit3=d), level-held by each requester.
REQ-005 Port gnt, output, 4, SHALL be the registered one-hot grant; all-zero when no owner.
REQ-006 Port sel, output, 2, SHALL be the registered select driving the downstream 4:1 tristate mux (00=a, 01=b, 10=c, 11=d).
REQ-007 Port bus_en, output, 1, SHALL be the registered tristate-enable for the downstream mux; 1 only in GRANT.
REQ-008 Port owner_cnt, output, 4, SHALL be the current owner's consecutive-grant count.

Function
REQ-009 The block SHALL be a three-state FSM: IDLE, GRANT, GAP.
REQ-010 Arbitration SHALL occur only on an edge where state is IDLE or GAP and req != 0.
REQ-011 Arbitration SHALL be round-robin: search order starts at (last_owner+1) mod 4 and wraps; the first set req bit wins.
REQ-012 On arbitration the block SHALL enter GRANT: gnt = one-hot(winner), sel = winner, bus_en = 1, owner_cnt = 0, last_owner = winner, all visible in the cycle after the sampling edge (1-cycle latency).
REQ-013 In GRANT, owner_cnt SHALL increment by 1 per cycle, saturating at HOLD_MAX-1.
REQ-014 In GRANT, if req[owner] = 0 at an edge, the next state SHALL be GAP.
REQ-015 In GRANT, if owner_cnt = HOLD_MAX-1 and any other req bit = 1 at an edge, the next state SHALL be GAP (preemption), regardless of req[owner].
REQ-016 In GRANT, if owner_cnt = HOLD_MAX-1 and no other req bit is set, the owner SHALL stay in GRANT with owner_cnt held at HOLD_MAX-1.
REQ-017 GAP SHALL last exactly one cycle with gnt = 0, bus_en = 0, sel holding last_owner, owner_cnt = 0; this dead cycle prevents tristate driver overlap.
REQ-018 From GAP, the next state SHALL be GRANT if req != 0 (per REQ-011/REQ-012), else IDLE.
REQ-019 In IDLE, gnt = 0, bus_en = 0, sel SHALL hold last_owner, owner_cnt = 0; with req = 0 the state SHALL remain IDLE.
REQ-020 The owner SHALL never change without an intervening GAP cycle; two consecutive GRANT cycles SHALL always have the same gnt.
REQ-021 gnt SHALL always be zero or one-hot, and bus_en SHALL equal |gnt in every cycle.
REQ-022 A request bit dropped and re-raised during GAP SHALL be treated by its level at the arbitration edge only.
REQ-023 With HOLD_MAX = 1, a contended owner SHALL be preempted after 1 GRANT cycle.

Reset
REQ-024 While rst_n = 0 at a rising edge, next state SHALL be IDLE, gnt = 0000, sel = 00, bus_en = 0, owner_cnt = 0, last_owner = 3 (so requester 0 has top priority first).
REQ-025 Reset asserted mid-GRANT SHALL drop bus_en and gnt in the cycle after the sampled edge; the requests pending at reset SHALL be ignored until the first edge with rst_n = 1.
REQ-026 The first arbitration after reset release SHALL occur on the first edge with rst_n = 1 and req != 0.

Verification
REQ-027 Reset, then req=0001 -> next cycle gnt=0001, sel=00, bus_en=1; hold 6 cycles uncontended -> owner_cnt saturates at 3, gnt unchanged.
REQ-028 req=1111 held, HOLD_MAX=4 -> grant sequence a,b,c,d,a, each owner 4 GRANT cycles separated by one GAP (bus_en=0, gnt=0000).
REQ-029 Owner b (gnt=0010) drops req[1] after 2 cycles with req=0100 pending -> one GAP cycle, then gnt=0100, sel=10.
REQ-030 All req drop during GRANT -> GAP then IDLE; sel holds last owner, bus_en=0, gnt=0000.
REQ-031 rst_n=0 for one edge mid-GRANT of d with req=1111 -> gnt=0000, sel=00; after release first grant is a (gnt=0001).
REQ-032 Every cycle of all scenarios: gnt zero or one-hot, bus_en == |gnt, no owner change without GAP.
